// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl: host-facing instruction FIFO feeding a processor one word
// at a time. Each word is held on iin for HOLD cycles, or less if the
// processor raises done. proc_resetn is kept low for RST_CYCLES edges after
// reset releases.
module instr_issue_ctrl #(
  parameter int DEPTH      = 4,
  parameter int HOLD       = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     done,
  output logic [15:0]              iin,
  output logic                     issue,
  output logic                     proc_resetn,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_EXEC     = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]   iin_q, iin_d;
  logic          issue_q, issue_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   mem_q [DEPTH];

  logic push;
  logic pop;

  // Full FIFO refuses pushes even when a pop frees a slot on the same edge.
  assign in_ready = !reset && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  // Sequencer: reset hold, idle wait, and back-to-back issue with hold timer.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    hold_cnt_d = hold_cnt_q;
    iin_d      = iin_q;
    issue_d    = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // Only words already stored may pop; no same-edge bypass.
        if (count_q != '0) pop = 1'b1;
      end
      ST_EXEC: begin
        if (hold_cnt_q == '0 || done) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase
    if (pop) begin
      iin_d      = mem_q[rptr_q];
      hold_cnt_d = HW'(HOLD - 1);
      issue_d    = 1'b1;
      state_d    = ST_EXEC;
    end
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally.
  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RST_HOLD;
      rst_cnt_q  <= '0;
      hold_cnt_q <= '0;
      iin_q      <= 16'h0000;
      issue_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      iin_q      <= iin_d;
      issue_q    <= issue_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Storage array; contents are don't-care once the pointers are flushed.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  assign iin         = iin_q;
  assign issue       = issue_q;
  assign busy        = (state_q == ST_EXEC);
  assign proc_resetn = (state_q != ST_RST_HOLD);
  assign count       = count_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: a queue-based reference model tracks the
// expected outputs every cycle, and directed scenarios pin literal values.
module tb_instr_issue_ctrl;
  localparam int DEPTH      = 4;
  localparam int HOLD       = 4;
  localparam int RST_CYCLES = 2;

  logic        clock, reset;
  logic [15:0] in_data;
  logic        in_valid, done;
  logic        in_ready;
  logic [15:0] iin;
  logic        issue, proc_resetn, busy;
  logic [2:0]  count;

  instr_issue_ctrl #(.DEPTH(DEPTH), .HOLD(HOLD), .RST_CYCLES(RST_CYCLES)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .done(done), .iin(iin), .issue(issue),
    .proc_resetn(proc_resetn), .busy(busy), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp, n_bad;
  bit chk_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending words, reset-hold countdown, and the
  // age of the word currently on the processor bus.
  logic [15:0] mq[$];
  int          m_rst_left;
  bit          m_active;
  int          m_age;
  logic [15:0] m_iin;
  bit          m_issue;

  initial begin
    bit take, push_ok;
    mq.delete(); m_rst_left = RST_CYCLES; m_active = 0; m_age = 0; m_iin = 0; m_issue = 0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        mq.delete(); m_rst_left = RST_CYCLES; m_active = 0; m_age = 0; m_iin = 0; m_issue = 0;
      end else begin
        push_ok = in_valid && (mq.size() < DEPTH);
        take = 0;
        if (m_rst_left > 0) m_rst_left--;
        else if (!m_active) take = (mq.size() > 0);
        else if (m_age >= HOLD || done) begin
          take = (mq.size() > 0);
          if (!take) m_active = 0;
        end else m_age++;
        m_issue = take;
        if (take) begin m_iin = mq.pop_front(); m_active = 1; m_age = 1; end
        if (push_ok) mq.push_back(in_data);
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("m_in_ready", in_ready, (!reset && mq.size() < DEPTH));
      check("m_iin", iin, m_iin);
      check("m_issue", issue, m_issue);
      check("m_busy", busy, m_active);
      check("m_proc_resetn", proc_resetn, (m_rst_left == 0));
      check("m_count", count, mq.size());
    end
  end

  task automatic drive(input logic v, input logic [15:0] d, input logic dn);
    @(negedge clock);
    #1;
    in_valid = v; in_data = d; done = dn;
  endtask

  logic [15:0] prog [4];
  logic [15:0] acc[$];
  logic [15:0] iss[$];
  int nb, np, nbusy, found, stale, nacc, nref, full_seen;
  int pt [8];
  logic [15:0] pw [8];

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 0;
    reset = 0; in_valid = 0; done = 0; in_data = 0;
    prog[0] = 16'hA01C; prog[1] = 16'hA40A; prog[2] = 16'h2080; prog[3] = 16'h8000;
    #1 reset = 1;
    repeat (3) @(negedge clock);
    chk_en = 1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_iin", iin, 0);
    check("rst_proc_resetn", proc_resetn, 0);
    reset = 0;

    // Reset release: proc_resetn rises on the second edge.
    drive(0, 0, 0);
    check("rel_prn_e1", proc_resetn, 0);
    check("rel_busy", busy, 0);
    drive(0, 0, 0);
    check("rel_prn_e2", proc_resetn, 1);
    check("rel_iin", iin, 0);
    check("rel_count", count, 0);

    // Single issue.
    drive(1, 16'hA01C, 0);
    drive(0, 0, 0);
    check("single_count", count, 1);
    check("single_pre_iin", iin, 0);
    drive(0, 0, 0);
    check("single_iin", iin, 16'hA01C);
    check("single_issue", issue, 1);
    nb = 0;
    for (int i = 0; i < 20 && busy; i++) begin nb++; drive(0, 0, 0); end
    check("single_busy_len", nb, 4);
    check("single_iin_idle", iin, 16'hA01C);
    check("single_issue_idle", issue, 0);

    // Back-to-back program.
    np = 0; nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      drive(c < 4, (c < 4) ? prog[c] : 16'h0, 0);
      if (busy) nbusy++;
      if (issue && np < 8) begin pt[np] = c; pw[np] = iin; np++; end
    end
    check("b2b_pulses", np, 4);
    for (int k = 0; k < 4 && k < np; k++) check("b2b_word", pw[k], prog[k]);
    for (int k = 1; k < 4 && k < np; k++) check("b2b_spacing", pt[k] - pt[k-1], 4);
    check("b2b_busy_total", nbusy, 16);

    // Early done on the second cycle of 2080.
    drive(1, 16'h1111, 0); drive(1, 16'h2080, 0); drive(1, 16'h8000, 0);
    found = 0;
    for (int c = 0; c < 30; c++) begin
      drive(0, 0, 0);
      if (issue && iin == 16'h2080) begin found = 1; break; end
    end
    check("edone_found", found, 1);
    drive(0, 0, 1);
    check("edone_c2_iin", iin, 16'h2080);
    check("edone_c2_issue", issue, 0);
    drive(0, 0, 0);
    check("edone_next_iin", iin, 16'h8000);
    check("edone_next_issue", issue, 1);
    for (int c = 0; c < 20 && busy; c++) drive(0, 0, 0);

    // Full FIFO: push until 6 accepted while words drain.
    acc.delete(); iss.delete(); nacc = 0; nref = 0; full_seen = 0;
    drive(1, 16'h3000, 0);
    for (int c = 0; c < 80 && (nacc < 6 || busy || count != 0); c++) begin
      drive(nacc < 6, 16'(16'h4000 + c), 0);
      if (issue) iss.push_back(iin);
      if (in_valid) begin
        if (in_ready) begin acc.push_back(in_data); nacc++; end
        else nref++;
      end
      if (count == 4) begin full_seen = 1; check("full_in_ready", in_ready, 0); end
    end
    check("full_seen", full_seen, 1);
    check("full_refused", (nref > 0), 1);
    check("full_issued_n", iss.size(), acc.size() + 1);
    if (iss.size() == acc.size() + 1) begin
      check("full_first", iss[0], 16'h3000);
      for (int k = 0; k < acc.size(); k++) check("full_order", iss[k+1], acc[k]);
    end

    // Reset in the third cycle of an instruction with two words queued.
    drive(1, 16'h5001, 0); drive(1, 16'h5002, 0); drive(1, 16'h5003, 0);
    drive(0, 0, 0); drive(0, 0, 0);
    check("mid_pre_iin", iin, 16'h5001);
    check("mid_pre_count", count, 2);
    reset = 1;
    #1;
    check("mid_iin", iin, 0);
    check("mid_issue", issue, 0);
    check("mid_busy", busy, 0);
    check("mid_prn", proc_resetn, 0);
    check("mid_count", count, 0);
    check("mid_in_ready", in_ready, 0);
    @(negedge clock); #1 reset = 0;
    stale = 0;
    for (int c = 0; c < 30; c++) begin drive(0, 0, 0); if (issue) stale++; end
    check("mid_stale", stale, 0);
    check("mid_prn_after", proc_resetn, 1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        @(negedge clock); #1 reset = 1; in_valid = 0; done = 0;
        @(negedge clock); #1 reset = 0;
      end else begin
        drive(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 4) == 0));
      end
    end
    drive(0, 0, 0);
    @(negedge clock);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_issue_ctrl.md
INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, is the instruction FIFO depth in entries and SHALL be a power of two, at least 2.
REQ-002 Parameter HOLD, default 4, is the number of clock cycles each instruction is presented on iin when done is not asserted; HOLD SHALL be at least 1.
REQ-003 Parameter RST_CYCLES, default 2, is the number of cycles proc_resetn stays low after reset deasserts; RST_CYCLES SHALL be at least 1.
REQ-004 Port clock  input  1  is the sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  is the asynchronous, active-high reset.
REQ-006 Port in_data  input  16  is the instruction word from the host.
REQ-007 Port in_valid  input  1  means in_data is valid.
REQ-008 Port in_ready  output  1  means the FIFO can accept a word this cycle.
REQ-009 Port done  input  1  means the processor has finished the current instruction (early advance).
REQ-010 Port iin  output  16  is the instruction word driven to the processor, registered.
REQ-011 Port issue  output  1  is a one-cycle pulse in the first cycle a new word appears on iin.
REQ-012 Port proc_resetn  output  1  is the active-low processor reset.
REQ-013 Port busy  output  1  is high while the controller is in state EXEC.
REQ-014 Port count  output  $clog2(DEPTH)+1  is the current FIFO occupancy.

Function
REQ-015 A push SHALL occur on a rising edge only when in_valid=1 and in_ready=1; in_ready SHALL equal (count<DEPTH), so pushes are refused when the FIFO is full, even in a cycle where a pop occurs.
REQ-016 The FIFO SHALL be first-in first-out, with wrap-around read and write pointers; a push and a pop on the same edge SHALL leave count unchanged.
REQ-017 There SHALL be no bypass path: a word pushed into an empty FIFO SHALL be popped on the next edge at the earliest.
REQ-018 The FSM SHALL have exactly three states: RST_HOLD, IDLE and EXEC.
REQ-019 In RST_HOLD, proc_resetn=0; after reset deasserts, a counter SHALL run for RST_CYCLES edges, and the FSM SHALL then go to IDLE with proc_resetn=1.
REQ-020 On each edge in IDLE with count>0, the controller SHALL pop the head word into iin, load hold_cnt=HOLD-1, and go to EXEC; issue SHALL be 1 in the first EXEC cycle.
REQ-021 In EXEC, the instruction ends in a cycle where hold_cnt==0 or done==1; otherwise hold_cnt SHALL decrement.
REQ-022 When an instruction ends with count>0, the controller SHALL pop the next word into iin back-to-back, remain in EXEC, reload hold_cnt=HOLD-1, and pulse issue again; with count==0 it SHALL go to IDLE.
REQ-023 Without done, each instruction SHALL therefore occupy iin for exactly HOLD cycles; with done, for at least 1 cycle.
REQ-024 The done input SHALL be ignored in RST_HOLD and IDLE.
REQ-025 In IDLE, iin SHALL hold the last issued word, and issue and busy SHALL be 0.
REQ-026 Pushes SHALL be accepted in every state, including RST_HOLD.

Reset
REQ-027 Asserting reset at any time, including mid-instruction, SHALL immediately and asynchronously force the following: state=RST_HOLD, FIFO flushed (count=0, pointers=0), iin=16'h0000, issue=0, busy=0, proc_resetn=0, hold_cnt=0.
REQ-028 While reset is high, in_ready SHALL be 0.

Verification
REQ-029 Reset release: proc_resetn rises exactly 2 edges after reset deasserts; iin=0, count=0 and busy=0 throughout.
REQ-030 Single issue: push 16'hA01C once in IDLE. On the next edge iin=A01C, issue=1 for 1 cycle, and busy=1 for 4 cycles; the controller then returns to IDLE with iin still A01C.
REQ-031 Back-to-back program: push A01C, A40A, 2080, 8000 on consecutive cycles. Each word is held on iin for exactly 4 cycles, in order, with 4 issue pulses spaced 4 cycles apart and no idle gap between them.
REQ-032 Early done: with 2080 and 8000 queued, pulse done in the 2nd cycle of 2080. 8000 appears on the next edge, so 2080 was held for 2 cycles.
REQ-033 Full FIFO: push 6 words while in EXEC with HOLD=4. in_ready drops when count=4; a push attempted in the same cycle as a pop is refused; no word is lost or duplicated.
REQ-034 Reset mid-operation: assert reset in the 3rd cycle of an instruction with 2 words queued. All outputs reach their reset values immediately; after release, no stale word is issued.
